// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button conditioner.
//   rep_state_e : per-channel auto-repeat state.
//   cnt_width() : bit width of a counter that runs 0 .. max_count-1 (at least 1 bit).
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2,
        ST_HOLD   = 2'd3
    } rep_state_e;

    function automatic int unsigned cnt_width(input int unsigned max_count);
        if (max_count <= 32'd2) begin
            return 32'd1;
        end else begin
            return $clog2(max_count);
        end
    endfunction

endpackage

// File: rtl/button_channel.sv
// One conditioned button: synchroniser, debouncer and auto-repeat FSM.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   raw         : unsynchronised active-high input
//   repeat_en   : auto-repeat enable (synchronous)
//   level       : debounced level
//   press       : 1-cycle strobe on accepted 0->1
//   rel         : 1-cycle strobe on accepted 1->0 ("release" is a reserved word)
//   pulse       : press OR auto-repeat strobe
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 32'd2,
    parameter int unsigned DEBOUNCE_CYCLES = 32'd1_000_000,
    parameter int unsigned REPEAT_DELAY    = 32'd50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 32'd10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic repeat_en,
    output logic level,
    output logic press,
    output logic rel,
    output logic pulse
);

    localparam int unsigned DW      = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW      = cnt_width(REP_MAX);

    localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 32'd1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 32'd1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [DW-1:0]          dcnt_r;
    logic [DW-1:0]          dcnt_nxt_s;
    logic [RW-1:0]          rcnt_r;
    logic [RW-1:0]          rcnt_nxt_s;
    rep_state_e             state_r;
    rep_state_e             state_nxt_s;
    logic                   s_s;
    logic                   toggle_s;
    logic                   rise_s;
    logic                   fall_s;
    logic                   rep_s;
    logic                   level_r;
    logic                   press_r;
    logic                   rel_r;
    logic                   pulse_r;

    assign s_s    = sync_r[SYNC_STAGES-1];
    assign rise_s = toggle_s & ~level_r;
    assign fall_s = toggle_s & level_r;

    // Debounce: count consecutive cycles where the synchronised input disagrees with level
    always_comb begin
        dcnt_nxt_s = '0;
        toggle_s   = 1'b0;
        if (s_s != level_r) begin
            if (dcnt_r == DEB_LAST) begin
                toggle_s   = 1'b1;
                dcnt_nxt_s = '0;
            end else begin
                dcnt_nxt_s = dcnt_r + 1'b1;
            end
        end else begin
            dcnt_nxt_s = '0;
        end
    end

    // Repeat FSM next state; a release always wins over a repeat tick or enable drop
    always_comb begin
        state_nxt_s = state_r;
        rcnt_nxt_s  = rcnt_r;
        rep_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                rcnt_nxt_s = '0;
                if (rise_s) begin
                    state_nxt_s = repeat_en ? ST_DELAY : ST_HOLD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                if (fall_s) begin
                    state_nxt_s = ST_IDLE;
                    rcnt_nxt_s  = '0;
                end else if (!repeat_en) begin
                    // Once dropped, repeats stay off until the next press
                    state_nxt_s = ST_HOLD;
                    rcnt_nxt_s  = '0;
                end else if (rcnt_r == ((state_r == ST_DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
                    rep_s       = 1'b1;
                    state_nxt_s = ST_REPEAT;
                    rcnt_nxt_s  = '0;
                end else begin
                    rcnt_nxt_s  = rcnt_r + 1'b1;
                end
            end
            ST_HOLD: begin
                rcnt_nxt_s = '0;
                if (fall_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                rcnt_nxt_s  = '0;
            end
        endcase
    end

    // State, counters, synchroniser and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r  <= '0;
            dcnt_r  <= '0;
            rcnt_r  <= '0;
            state_r <= ST_IDLE;
            level_r <= 1'b0;
            press_r <= 1'b0;
            rel_r   <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], raw};
            dcnt_r  <= dcnt_nxt_s;
            rcnt_r  <= rcnt_nxt_s;
            state_r <= state_nxt_s;
            level_r <= level_r ^ toggle_s;
            press_r <= rise_s;
            rel_r   <= fall_s;
            pulse_r <= rise_s | rep_s;
        end
    end

    assign level = level_r;
    assign press = press_r;
    assign rel   = rel_r;
    assign pulse = pulse_r;

endmodule

// File: rtl/button_conditioner.sv
// N-channel button conditioner: one independent button_channel per input.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   raw        : N unsynchronised active-high inputs
//   repeat_en  : N per-channel auto-repeat enables
//   level      : N debounced levels
//   press      : N press strobes
//   rel        : N release strobes ("release" is a reserved word)
//   pulse      : N press-or-repeat strobes, wired to the main module
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned N               = 32'd5,
    parameter int unsigned SYNC_STAGES     = 32'd2,
    parameter int unsigned DEBOUNCE_CYCLES = 32'd1_000_000,
    parameter int unsigned REPEAT_DELAY    = 32'd50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 32'd10_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] raw,
    input  logic [N-1:0] repeat_en,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] rel,
    output logic [N-1:0] pulse
);

    for (genvar g = 0; g < int'(N); g++) begin : g_ch
        button_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .raw       (raw[g]),
            .repeat_en (repeat_en[g]),
            .level     (level[g]),
            .press     (press[g]),
            .rel       (rel[g]),
            .pulse     (pulse[g])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus random
// stimulus, compared every cycle against a behavioural reference model.
module tb_button_conditioner;

    localparam int N  = 2;
    localparam int SS = 2;
    localparam int DC = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] raw = '0;
    logic [N-1:0] repeat_en = '0;
    logic [N-1:0] level, press, rel, pulse;

    always #5 clk = ~clk;

    button_conditioner #(
        .N(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .raw(raw), .repeat_en(repeat_en),
        .level(level), .press(press), .rel(rel), .pulse(pulse)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state
    bit raw_hist [N][$];
    bit s_hist   [N][$];
    bit lvl_m [N];
    bit prs_m [N];
    bit rel_m [N];
    bit pls_m [N];
    int press_edge [N];
    bit rep_ok [N];

    // Channel-0 event logs (cycle numbers)
    int press_q[$];
    int pulse_q[$];
    int rel_q[$];

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            raw_hist[c].delete();
            s_hist[c].delete();
            lvl_m[c] = 1'b0; prs_m[c] = 1'b0; rel_m[c] = 1'b0; pls_m[c] = 1'b0;
            press_edge[c] = 0; rep_ok[c] = 1'b0;
        end
    endtask

    // Level changes once the synchronised input has disagreed with it for DC
    // consecutive edges; repeats fire at press+RD, press+RD+k*RP while the
    // enable has stayed high since the press.
    task automatic model_step();
        bit s_b, new_l, rise, fall, rep, all_diff;
        int dt;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int c = 0; c < N; c++) begin
            s_b = (raw_hist[c].size() >= SS) ? raw_hist[c][raw_hist[c].size() - SS] : 1'b0;
            raw_hist[c].push_back(raw[c]);
            if (raw_hist[c].size() > SS) void'(raw_hist[c].pop_front());
            s_hist[c].push_back(s_b);
            if (s_hist[c].size() > DC) void'(s_hist[c].pop_front());
            all_diff = (s_hist[c].size() == DC);
            for (int k = 0; k < s_hist[c].size(); k++)
                if (s_hist[c][k] == lvl_m[c]) all_diff = 1'b0;
            new_l = all_diff ? ~lvl_m[c] : lvl_m[c];
            rise  = new_l & ~lvl_m[c];
            fall  = ~new_l & lvl_m[c];
            rep   = 1'b0;
            if (rise) begin
                press_edge[c] = cyc;
                rep_ok[c]     = repeat_en[c];
            end else if (fall) begin
                rep_ok[c] = 1'b0;
            end else if (lvl_m[c] && rep_ok[c]) begin
                dt = cyc - press_edge[c];
                if (!repeat_en[c]) rep_ok[c] = 1'b0;
                else if (dt >= RD && ((dt - RD) % RP) == 0) rep = 1'b1;
            end
            lvl_m[c] = new_l;
            prs_m[c] = rise;
            rel_m[c] = fall;
            pls_m[c] = rise | rep;
        end
    endtask

    task automatic chk(string name, int c, logic obs, bit exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d] cyc %0d observed %b expected %b", name, c, cyc, obs, exp);
        end
    endtask

    task automatic chk_rng(string name, int obs, int lo, int hi);
        n_assert++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s observed %0d expected %0d..%0d", name, obs, lo, hi);
        end
    endtask

    task automatic check_outputs();
        for (int c = 0; c < N; c++) begin
            chk("level", c, level[c], lvl_m[c]);
            chk("press", c, press[c], prs_m[c]);
            chk("release", c, rel[c], rel_m[c]);
            chk("pulse", c, pulse[c], pls_m[c]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        check_outputs();
        if (press[0] === 1'b1) press_q.push_back(cyc);
        if (pulse[0] === 1'b1) pulse_q.push_back(cyc);
        if (rel[0] === 1'b1)   rel_q.push_back(cyc);
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    task automatic clear_logs();
        press_q.delete(); pulse_q.delete(); rel_q.delete();
    endtask

    task automatic wait_press(output int pc, input int budget);
        int k;
        k  = 0;
        pc = -1;
        while (k < budget && pc < 0) begin
            tick();
            k++;
            if (press[0] === 1'b1) pc = cyc;
        end
        chk_rng("wait_press_timeout", pc, 0, 32'h7fff_ffff);
    endtask

    function automatic int qget(int q[$], int k);
        return (q.size() > k) ? q[k] : -1000;
    endfunction

    initial begin
        int t0, t1, p, p2, r;
        model_reset();

        // Reset state
        run(3);
        rst_n = 1'b1;
        run(4);

        // Clean press, repeat disabled
        clear_logs();
        raw[0] = 1'b1; t0 = cyc;
        run(20);
        raw[0] = 1'b0; t1 = cyc;
        run(12);
        chk_rng("clean_press_count", press_q.size(), 1, 1);
        chk_rng("clean_pulse_count", pulse_q.size(), 1, 1);
        chk_rng("clean_press_latency", qget(press_q, 0) - t0, 5, 7);
        chk_rng("clean_release_latency", qget(rel_q, 0) - t1, 5, 7);

        // Bounce rejection
        clear_logs();
        for (int i = 0; i < 10; i++) begin
            raw[0] = ~raw[0];
            run(3);
        end
        chk_rng("bounce_no_press", press_q.size(), 0, 0);
        raw[0] = 1'b1; t0 = cyc;
        run(12);
        chk_rng("bounce_press_count", press_q.size(), 1, 1);
        chk_rng("bounce_press_latency", qget(press_q, 0) - t0, 5, 7);
        raw[0] = 1'b0;
        run(12);

        // Auto-repeat
        clear_logs();
        repeat_en[0] = 1'b1;
        raw[0] = 1'b1;
        wait_press(p, 20);
        run(30);
        chk_rng("rep_press_count", press_q.size(), 1, 1);
        chk_rng("rep_pulse0", qget(pulse_q, 0) - p, 0, 0);
        chk_rng("rep_pulse1", qget(pulse_q, 1) - p, RD, RD);
        chk_rng("rep_pulse2", qget(pulse_q, 2) - p, RD + RP, RD + RP);
        chk_rng("rep_pulse3", qget(pulse_q, 3) - p, RD + 2 * RP, RD + 2 * RP);
        raw[0] = 1'b0;
        run(12);

        // Repeat abort, re-enable ignored while held
        clear_logs();
        raw[0] = 1'b1;
        wait_press(p, 20);
        run(11);
        repeat_en[0] = 1'b0;
        run(4);
        repeat_en[0] = 1'b1;
        run(15);
        chk_rng("abort_pulse_count", pulse_q.size(), 2, 2);
        raw[0] = 1'b0;
        run(12);
        clear_logs();
        raw[0] = 1'b1;
        wait_press(p2, 20);
        run(12);
        chk_rng("resume_repeat", qget(pulse_q, 1) - p2, RD, RD);
        raw[0] = 1'b0;
        run(12);

        // Release coinciding with repeat tick at press+13
        clear_logs();
        raw[0] = 1'b1;
        wait_press(p, 20);
        run(7);
        raw[0] = 1'b0;
        run(10);
        chk_rng("tick_release_cycle", qget(rel_q, 0) - p, RD + RP, RD + RP);
        chk_rng("tick_pulse_count", pulse_q.size(), 2, 2);

        // Async reset mid-hold
        clear_logs();
        raw[0] = 1'b1;
        wait_press(p, 20);
        run(5);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_level", 0, level[0], 1'b0);
        chk("rst_press", 0, press[0], 1'b0);
        chk("rst_release", 0, rel[0], 1'b0);
        chk("rst_pulse", 0, pulse[0], 1'b0);
        run(2);
        rst_n = 1'b1; r = cyc;
        clear_logs();
        wait_press(p, 20);
        chk_rng("post_reset_press_latency", p - r, 5, 7);
        chk_rng("post_reset_no_release", rel_q.size(), 0, 0);
        raw[0] = 1'b0;
        run(12);

        // Random stimulus on both channels
        for (int i = 0; i < 60; i++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 2) != 0) raw[c] = $urandom_range(0, 1);
                if ($urandom_range(0, 4) == 0) repeat_en[c] = $urandom_range(0, 1);
            end
            run($urandom_range(1, 25));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
